// File: rtl/axicb_pri_rr_arbiter.sv
// rtl/axicb_pri_rr_arbiter.sv - priority-layered round-robin arbiter with grant locking
// Optional lock watchdog: define AXICB_RR_TIMEOUT_EN.
module axicb_pri_rr_arbiter #(
   parameter int                  REQ_NB     = 4,
   parameter logic [2*REQ_NB-1:0] PRIORITIES = '0,
   parameter int                  TIMEOUT    = 256,
   localparam int                 IDW        = (REQ_NB > 2) ? $clog2(REQ_NB) : 1
) (
   input  logic              aclk,
   input  logic              srst,
   input  logic              en,
   input  logic [REQ_NB-1:0] req,
   input  logic              done,
   output logic [REQ_NB-1:0] grant,
   output logic [IDW-1:0]    grant_id,
   output logic              busy,
   output logic              timeout
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                       state;
   logic [3:0][REQ_NB-1:0]       mask;
   logic [3:0][REQ_NB-1:0]       members;
   logic [1:0]                   layer;
   logic [REQ_NB-1:0]            in_layer;
   logic [REQ_NB-1:0]            cand;
   logic [REQ_NB-1:0]            next_mask;
   logic [IDW-1:0]               winner;
   logic                         user_rel;
   logic                         force_rel;
   logic                         rel;
   logic                         take;

   always_comb begin
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < REQ_NB; i++)
            members[l][i] = (PRIORITIES[2*i +: 2] == 2'(l));
   end

   // Highest populated layer wins outright; round-robin only inside that layer.
   always_comb begin
      layer = 2'd0;
      for (int l = 0; l < 4; l++)
         if ((req & members[l]) != '0) layer = 2'(l);
      in_layer = req & members[layer];
      cand     = in_layer & mask[layer];
      if (cand == '0) cand = in_layer;
      winner = '0;
      for (int i = REQ_NB - 1; i >= 0; i--)
         if (cand[i]) winner = IDW'(i);
      next_mask = '0;
      for (int i = 0; i < REQ_NB; i++)
         if (members[layer][i] && (i > int'(winner))) next_mask[i] = 1'b1;
      if (next_mask == '0) next_mask = '1;
   end

   assign user_rel = (state == LOCKED) && (done || !req[grant_id]);
   assign rel      = user_rel || force_rel;
   assign take     = en && (|req) && ((state == IDLE) || rel);

`ifdef AXICB_RR_TIMEOUT_EN
   logic [15:0] wd_cnt;

   assign force_rel = (state == LOCKED) && (wd_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge aclk) begin
      if (srst || take)
         wd_cnt <= '0;
      else if ((state == LOCKED) && (wd_cnt != 16'hFFFF))
         wd_cnt <= wd_cnt + 16'd1;
   end
`else
   // Always false; keeps TIMEOUT referenced when the watchdog is absent.
   assign force_rel = (TIMEOUT < 0);
`endif

   always_ff @(posedge aclk) begin
      if (srst) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         mask     <= '1;
      end else begin
         timeout <= force_rel && !user_rel;
         if (take) begin
            state       <= LOCKED;
            grant       <= REQ_NB'(1) << winner;
            grant_id    <= winner;
            busy        <= 1'b1;
            mask[layer] <= next_mask;
         end else if ((state == IDLE) || rel) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axicb_pri_rr_arbiter.sv
// tb/tb_axicb_pri_rr_arbiter.sv - directed and randomized checks of axicb_pri_rr_arbiter
// Two instances: 4 requesters flat priority, 6 requesters mixed priority layers.
module tb_axicb_pri_rr_arbiter;

   localparam int TO = 8;
`ifdef AXICB_RR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int              NA     = 4;
   localparam int              NB     = 6;
   localparam logic [2*NB-1:0] PRIO_B = 12'hE10;

   logic       aclk = 1'b0;
   logic       srst = 1'b1;
   logic       en   = 1'b0;
   logic       done = 1'b0;
   logic [5:0] req  = '0;

   logic [3:0] grant_a;
   logic [1:0] id_a;
   logic       busy_a, to_a;
   logic [5:0] grant_b;
   logic [2:0] id_b;
   logic       busy_b, to_b;

   int checks   = 0;
   int failures = 0;

   int nb [2];
   int prio [2][6];
   bit locked [2];
   bit rst_seen [2];
   bit exp_to [2];
   int owner [2];
   int cnt [2];
   bit msk [2][4][6];

   always #5 aclk = ~aclk;

   axicb_pri_rr_arbiter #(.REQ_NB(NA), .PRIORITIES('0), .TIMEOUT(TO)) dut_a (
      .aclk(aclk), .srst(srst), .en(en), .req(req[3:0]), .done(done),
      .grant(grant_a), .grant_id(id_a), .busy(busy_a), .timeout(to_a)
   );

   axicb_pri_rr_arbiter #(.REQ_NB(NB), .PRIORITIES(PRIO_B), .TIMEOUT(TO)) dut_b (
      .aclk(aclk), .srst(srst), .en(en), .req(req), .done(done),
      .grant(grant_b), .grant_id(id_b), .busy(busy_b), .timeout(to_b)
   );

   // Reference: pick the top priority level present, walk its requesters in index
   // order, prefer the first one still marked eligible, else the first one.
   function automatic void model_step(input int k, input logic [5:0] r, input logic e,
                                      input logic d, input logic s);
      bit free, user_rel, forced, found, any;
      int q[$];
      int w, lay;
      rst_seen[k] = s;
      if (s) begin
         locked[k] = 0; owner[k] = 0; cnt[k] = 0; exp_to[k] = 0;
         for (int l = 0; l < 4; l++)
            for (int i = 0; i < 6; i++) msk[k][l][i] = 1;
         return;
      end
      exp_to[k] = 0;
      free = !locked[k];
      if (locked[k]) begin
         user_rel = d || !r[owner[k]];
         forced   = TO_EN && (cnt[k] == TO - 1);
         if (user_rel || forced) begin
            free      = 1;
            exp_to[k] = forced && !user_rel;
         end else if (cnt[k] < 65535) begin
            cnt[k]++;
         end
      end
      if (!free) return;
      locked[k] = 0;
      lay = -1;
      for (int p = 3; p >= 0; p--)
         if (lay < 0)
            for (int i = 0; i < nb[k]; i++)
               if (r[i] && prio[k][i] == p) lay = p;
      if (!e || lay < 0) return;
      for (int i = 0; i < nb[k]; i++)
         if (r[i] && prio[k][i] == lay) q.push_back(i);
      w = q[0];
      found = 0;
      foreach (q[j])
         if (!found && msk[k][lay][q[j]]) begin
            w = q[j];
            found = 1;
         end
      any = 0;
      for (int i = 0; i < 6; i++) begin
         msk[k][lay][i] = (i < nb[k]) && (prio[k][i] == lay) && (i > w);
         any |= msk[k][lay][i];
      end
      if (!any)
         for (int i = 0; i < 6; i++) msk[k][lay][i] = 1;
      locked[k] = 1;
      owner[k]  = w;
      cnt[k]    = 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare(input int k, input logic [5:0] g, input logic [2:0] id,
                          input logic b, input logic t);
      logic [5:0] eg;
      eg = locked[k] ? 6'(1 << owner[k]) : 6'd0;
      chk($sformatf("grant%0d", k), 32'(g), 32'(eg));
      chk($sformatf("busy%0d", k), 32'(b), 32'(locked[k]));
      chk($sformatf("timeout%0d", k), 32'(t), 32'(exp_to[k]));
      if (locked[k] || rst_seen[k])
         chk($sformatf("grant_id%0d", k), 32'(id), 32'(owner[k]));
   endtask

   task automatic step(input logic [5:0] r, input logic e, input logic d, input logic s);
      @(negedge aclk);
      req = r; en = e; done = d; srst = s;
      model_step(0, r, e, d, s);
      model_step(1, r, e, d, s);
      @(posedge aclk);
      #1;
      compare(0, {2'b00, grant_a}, {1'b0, id_a}, busy_a, to_a);
      compare(1, grant_b, id_b, busy_b, to_b);
   endtask

   initial begin
      logic [3:0] seq1 [5];
      logic [3:0] seq2 [6];
      logic [5:0] seq3 [4];
      logic [5:0] r;
      nb[0] = NA;
      nb[1] = NB;
      for (int i = 0; i < 6; i++) begin
         prio[0][i] = 0;
         prio[1][i] = int'(PRIO_B[2*i +: 2]);
      end
      seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      seq2 = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      seq3 = '{6'b000100, 6'b000100, 6'b000001, 6'b000010};

      step(6'h00, 1'b0, 1'b0, 1'b1);
      chk("reset_grant", 32'(grant_a), 32'd0);
      chk("reset_id", 32'(id_a), 32'd0);

      for (int i = 0; i < 5; i++) begin
         step(6'h0F, 1'b1, 1'b1, 1'b0);
         chk("p1_rr", 32'(grant_a), 32'(seq1[i]));
      end

      step(6'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step((i < 4) ? 6'h0D : 6'h0F, 1'b1, 1'b1, 1'b0);
         chk("p2_skip", 32'(grant_a), 32'(seq2[i]));
      end

      step(6'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step((i < 2) ? 6'h0F : 6'h0B, 1'b1, 1'b1, 1'b0);
         chk("p3_layers", 32'(grant_b), 32'(seq3[i]));
      end

      step(6'h00, 1'b0, 1'b0, 1'b1);
      step(6'h0F, 1'b1, 1'b0, 1'b0);
      step(6'h0F, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(6'h0F, logic'(i % 2), 1'b0, 1'b0);
         chk("p4_hold", 32'({busy_a, grant_a}), 32'({1'b1, 4'b0010}));
      end
      step(6'h0F, 1'b1, 1'b1, 1'b0);
      chk("p4_done", 32'(grant_a), 32'b0100);
      step(6'h00, 1'b0, 1'b0, 1'b1);
      step(6'h0F, 1'b1, 1'b0, 1'b0);
      step(6'h0F, 1'b1, 1'b1, 1'b0);
      step(6'h0D, 1'b1, 1'b0, 1'b0);
      chk("p4_abandon", 32'(grant_a), 32'b0100);

      step(6'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(6'h0F, 1'b1, 1'b1, 1'b0);
      chk("p5_pre", 32'(grant_a), 32'b1000);
      step(6'h0F, 1'b1, 1'b0, 1'b1);
      chk("p5_rst", 32'({busy_a, grant_a}), 32'd0);
      step(6'h0F, 1'b1, 1'b0, 1'b0);
      chk("p5_after", 32'(grant_a), 32'b0001);

      step(6'h00, 1'b0, 1'b0, 1'b1);
      step(6'h0F, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < TO - 1; i++) begin
         step(6'h0F, 1'b1, 1'b0, 1'b0);
         chk("p6_hold", 32'({to_a, grant_a}), 32'({1'b0, 4'b0001}));
      end
      step(6'h0F, 1'b1, 1'b0, 1'b0);
      chk("p6_expire", 32'({to_a, grant_a}),
          TO_EN ? 32'({1'b1, 4'b0010}) : 32'({1'b0, 4'b0001}));

      r = 6'h3F;
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 3) == 0) r = 6'($urandom);
         step(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 60) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axicb_pri_rr_arbiter.md
Name: axicb_pri_rr_arbiter

Overview:
Parametrised, priority-layered round-robin arbiter with grant locking, for the crossbar switch slices.
- Supports any requester count, not only 4 or 8.
- Four priority layers, each with its own round-robin mask.
- A registered grant stays locked to one requester until the transaction completes, so an AXI burst is never interleaved.
- Sits between the slave-interface request lines and the channel muxes.

Parameters:
- REQ_NB, 4: number of requesters; legal range 2..16.
- PRIORITIES, 0: packed REQ_NB*2 bits. Field i, bits [2i+1:2i], is requester i's priority. 3 is highest, 0 is lowest.
- TIMEOUT, 256: lock watchdog limit in cycles; legal range 2..65535. Used only with the optional feature.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- srst  in  1  synchronous reset, active-high.
- en  in  1  arbitration enable; a new grant is issued only while en=1.
- req  in  REQ_NB  request vector, level-sensitive.
- done  in  1  completion strobe for the currently granted requester (last handshake).
- grant  out  REQ_NB  one-hot registered grant; all zeros when idle.
- grant_id  out  max($clog2(REQ_NB),1)  binary index of the granted requester.
- busy  out  1  high while a grant is locked.
- timeout  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset:
  - srst=1 at a rising edge gives grant=0, grant_id=0, busy=0, timeout=0.
  - All four layer masks are set to all ones; state=IDLE; watchdog counter=0.
  - Reset overrides everything else, including mid-lock.
- FSM has two states, IDLE and LOCKED.
- Winner selection is combinational, computed every cycle:
  - Active layer L is the highest priority present among the set bits of req.
  - cand = req & members(L) & mask[L].
  - If cand=0, fall back to cand = req & members(L).
  - Winner is the lowest set index of cand.
  - Lower layers are not evaluated while a higher layer is active.
- IDLE:
  - If en && |req, then on the next edge: grant=onehot(winner), grant_id=winner, busy=1, state=LOCKED. Latency from req to grant is 1 cycle.
  - mask[L] becomes the members of L with index > winner. If that set is empty, mask[L] becomes all ones.
  - Masks of other layers are unchanged.
  - If en=0 or req=0, stay in IDLE with grant=0.
- LOCKED:
  - grant holds regardless of en and of other requests.
  - Release occurs when done=1, or when req[grant_id]=0 (requester abandoned).
  - On release with en && |req, re-arbitrate in the same edge using the already updated masks. Back-to-back grants have zero bubble.
  - The same requester may be re-granted if it is the only candidate.
  - On release otherwise: grant=0, busy=0, state=IDLE.
  - done while IDLE is ignored.
- Simultaneous events:
  - done and the abandon condition together count as one release.
  - A req edge on the winner in the same cycle as release has no special effect.
- grant and busy are always consistent: busy == |grant.
- Exactly one grant bit is ever set.

Optional Feature:
- Macro: AXICB_RR_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on every new grant and increments each LOCKED cycle.
  - When the count reaches TIMEOUT-1 without a release, the next edge forces release, with the same re-arbitration rules as a normal release.
  - timeout pulses high for exactly that cycle.
  - Masks update as for any grant.
  - The counter saturates and never wraps.
- Without the macro: no counter is instantiated, timeout is tied 0, and a lock can last indefinitely.

Test Plan:
1. REQ_NB=4, PRIORITIES=0, req=1111, en=1, done pulsed one cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle between grants.
2. req=1101, done every grant -> 0001, 0100, 1000, 0001; then req=1111 -> 0010, 0100.
3. PRIORITIES set so requester 2 is layer 1, req=1111 -> 0100, 0100; then drop req[2] -> 0001, 0010 (layer-0 mask unaffected by the layer-1 grants).
4. Grant 0010 locked, done=0 for 10 cycles with req=1111 and en toggling -> grant stays 0010 and busy=1; done=1 -> next cycle grant=0100. Separately, drop req[1] while it is locked -> grant=0100 next cycle.
5. srst=1 mid-lock on grant 1000 -> next cycle grant=0, busy=0; release srst with req=1111 -> grant=0001 (masks were reset).
6. With AXICB_RR_TIMEOUT_EN and TIMEOUT=8, grant 0001 held with done=0 -> timeout=1 on the cycle grant changes to 0010, exactly 8 cycles after the grant. Without the macro, same stimulus -> grant stays 0001 and timeout=0.
